mp_add_seq: RTL and testbench

MP_ADD_SEQ -- requirements
Module: mp_add_seq

---
 rtl/mp_add_seq.sv | 157 +++++++++++++++
 tb/tb_mp_add_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mp_add_seq.sv
// Multi-precision adder: one N-bit ripple-carry adder reused for K slices per operation (W = N*K).
// Define MP_ADD_SEQ_OVF_EN to add a registered two's-complement overflow output (ovf).

module mp_add_seq_rca #(
    parameter int N = 8
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         c_i,
    output logic [N-1:0] s_o,
    output logic         c_msb_o,
    output logic         c_o
);
    logic [N:0] c;

    assign c[0] = c_i;

    for (genvar g = 0; g < N; g++) begin : g_fa
        assign s_o[g]   = a_i[g] ^ b_i[g] ^ c[g];
        assign c[g + 1] = (a_i[g] & b_i[g]) | (c[g] & (a_i[g] ^ b_i[g]));
    end

    // carry into the slice MSB, needed only for signed overflow detection
    assign c_msb_o = c[N-1];
    assign c_o     = c[N];
endmodule

module mp_add_seq #(
    parameter int N = 8,
    parameter int K = 4,
    localparam int W = N * K
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         c_out,
`ifdef MP_ADD_SEQ_OVF_EN
    output logic         ovf,
`endif
    output logic         busy
);
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic           carry_q, carry_d;
    logic [W-1:0]   sum_q, sum_d;
    logic           cout_q, cout_d;
    logic           ovf_q, ovf_d;

    logic [N-1:0]   rca_a, rca_b, rca_s;
    logic           rca_cmsb, rca_c;
    logic           last_slice;

    assign rca_a      = a_q[cnt_q*N +: N];
    assign rca_b      = b_q[cnt_q*N +: N];
    assign last_slice = (cnt_q == CW'(K - 1));

    mp_add_seq_rca #(.N(N)) u_rca (
        .a_i     (rca_a),
        .b_i     (rca_b),
        .c_i     (carry_q),
        .s_o     (rca_s),
        .c_msb_o (rca_cmsb),
        .c_o     (rca_c)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = c_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[cnt_q*N +: N] = rca_s;
                carry_d             = rca_c;
                if (last_slice) begin
                    cout_d  = rca_c;
                    ovf_d   = rca_cmsb ^ rca_c;
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign c_out     = cout_q;

`ifdef MP_ADD_SEQ_OVF_EN
    assign ovf = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q ^ rca_cmsb;
`endif
endmodule

// File: tb/tb_mp_add_seq.sv
// Directed bench for mp_add_seq (N=8, K=4) with a scoreboard of expected {c_out, sum}.
module tb_mp_add_seq;
    localparam int N = 8;
    localparam int K = 4;
    localparam int W = N * K;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         c_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;
    logic         busy;
`ifdef MP_ADD_SEQ_OVF_EN
    logic         ovf;
    logic         ovfq[$];
`endif

    logic [W:0]   expq[$];
    int           vec  = 0;
    int           errs = 0;

    mp_add_seq #(.N(N), .K(K)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
`ifdef MP_ADD_SEQ_OVF_EN
        .ovf       (ovf),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(logic [W-1:0] av, logic [W-1:0] bv, logic cv);
        logic [W:0] full;
        @(negedge clk);
        a = av; b = bv; c_in = cv; in_valid = 1'b1;
        check("accept_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        full = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
        expq.push_back(full);
`ifdef MP_ADD_SEQ_OVF_EN
        ovfq.push_back((av[W-1] == bv[W-1]) && (full[W-1] != av[W-1]));
`endif
    endtask

    // Called right after the accepting edge; result must appear after exactly K more edges.
    task automatic wait_result(string tag, int hold);
        logic [W:0] e;
        for (int i = 1; i <= K; i++) begin
            @(posedge clk);
            #1;
            if (i < K) begin
                check({tag, "_early_valid"}, out_valid, 0);
                check({tag, "_run_in_ready"}, in_ready, 0);
                check({tag, "_run_busy"}, busy, 1);
            end
        end
        check({tag, "_out_valid"}, out_valid, 1);
        if (expq.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 1, 0);
            e = '0;
        end else begin
            e = expq.pop_front();
        end
        check({tag, "_sum"}, sum, e[W-1:0]);
        check({tag, "_c_out"}, c_out, e[W]);
`ifdef MP_ADD_SEQ_OVF_EN
        if (ovfq.size() != 0) check({tag, "_ovf"}, ovf, ovfq.pop_front());
`endif
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_sum"}, sum, e[W-1:0]);
            check({tag, "_hold_c_out"}, c_out, e[W]);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_idle_valid"}, out_valid, 0);
        check({tag, "_idle_in_ready"}, in_ready, 1);
        check({tag, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic [W:0]   full;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; c_in = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", sum, 0);
        check("rst_c_out", c_out, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        send(32'h0000_00FF, 32'h0000_0001, 1'b0);
        wait_result("slice_carry", 0);

        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        wait_result("full_ripple", 0);

        send(32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
        wait_result("backpressure", 3);

        // second request presented during RUN must wait for the DONE handshake
        send(32'h0F0F_0F0F, 32'h0101_0101, 1'b1);
        a = 32'hAAAA_AAAA; b = 32'h5555_5555; c_in = 1'b1; in_valid = 1'b1;
        wait_result("ignore_first", 1);
        full = {1'b0, 32'hAAAA_AAAA} + {1'b0, 32'h5555_5555} + 33'd1;
        expq.push_back(full);
`ifdef MP_ADD_SEQ_OVF_EN
        ovfq.push_back(1'b0);
`endif
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("ignore_second_accepted", in_ready, 0);
        wait_result("ignore_second", 0);

        send(32'hCAFE_F00D, 32'h8765_4321, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_sum", sum, 0);
        check("abort_c_out", c_out, 0);
        void'(expq.pop_back());
`ifdef MP_ADD_SEQ_OVF_EN
        check("abort_ovf", ovf, 0);
        void'(ovfq.pop_back());
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < K + 2; i++) begin
            @(posedge clk);
            #1;
            check("abort_no_result", out_valid, 0);
            check("abort_idle", in_ready, 1);
        end
        send(32'h1234_5678, 32'h1111_1111, 1'b0);
        wait_result("after_abort", 0);

`ifdef MP_ADD_SEQ_OVF_EN
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        wait_result("ovf_pos", 0);
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        wait_result("ovf_wrap", 0);
`endif

        for (int r = 0; r < 6; r++) begin
            ra = $urandom();
            rb = $urandom();
            send(ra, rb, 1'($urandom_range(0, 1)));
            wait_result("random", r % 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
